// File: rtl/uart_rx16.sv
// 8N1 serial receiver with 16x oversampling, a two-flop input synchroniser and
// three-sample majority voting. Each byte is reported as a one-cycle data_valid or frame_error pulse.
module uart_rx16 #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       rx_busy
);

    localparam int DIV = CLOCK_FREQ / (BAUD_RATE * 16);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sync1_q, sync2_q;
    logic [CW-1:0] div_cnt_q;
    logic          tick;
    logic          rx_sync;

    state_t        state_q, state_d;
    logic [3:0]    sample_cnt_q, sample_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    votes_q, votes_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          busy_q;

    logic          maj_q;
    logic          stop_maj;
    logic          stop_done;

    assign rx_sync = sync2_q;
    assign tick    = (div_cnt_q == CW'(DIV - 1));

    // Majority of the three stored votes, used at the end of START and DATA bits.
    assign maj_q    = (votes_q[0] & votes_q[1]) | (votes_q[0] & votes_q[2]) | (votes_q[1] & votes_q[2]);
    // The stop decision is taken on the tick of the third vote, so that vote is taken live.
    assign stop_maj = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_sync) | (votes_q[1] & rx_sync);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            div_cnt_q    <= '0;
            state_q      <= IDLE;
            sample_cnt_q <= 4'd0;
            bit_idx_q    <= 3'd0;
            votes_q      <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= rx_serial;
            sync2_q      <= sync1_q;
            div_cnt_q    <= tick ? '0 : div_cnt_q + CW'(1);
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            votes_q      <= votes_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            busy_q       <= (state_q != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        votes_d      = votes_q;
        shift_d      = shift_q;
        if (tick) begin
            if (state_q == IDLE) begin
                if (!rx_sync) begin
                    state_d      = START;
                    sample_cnt_d = 4'd0;
                end
            end else begin
                sample_cnt_d = sample_cnt_q + 4'd1;
                if (sample_cnt_q == 4'd7) votes_d[0] = rx_sync;
                if (sample_cnt_q == 4'd8) votes_d[1] = rx_sync;
                if (sample_cnt_q == 4'd9) votes_d[2] = rx_sync;
                case (state_q)
                    START: begin
                        if (sample_cnt_q == 4'd15) begin
                            if (maj_q) begin
                                state_d = IDLE;
                            end else begin
                                state_d   = DATA;
                                bit_idx_d = 3'd0;
                            end
                        end
                    end
                    DATA: begin
                        if (sample_cnt_q == 4'd15) begin
                            shift_d = {maj_q, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_d = STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (sample_cnt_q == 4'd9) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Output decode, registered one cycle later
    always_comb begin
        stop_done = tick && (state_q == STOP) && (sample_cnt_q == 4'd9);
        valid_d   = stop_done && stop_maj;
        ferr_d    = stop_done && !stop_maj;
        data_d    = valid_d ? shift_q : data_q;
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign rx_busy     = busy_q;

endmodule

// File: doc/uart_rx16.md
# uart_rx16

Asynchronous serial receiver, 8N1, LSB first: the receive counterpart of the project's UART transmitter. It recovers bytes from an idle-high serial line using an internal 16x oversampling tick, a 2-flop input synchroniser and 3-sample majority voting. It sits between the external RX pin and the byte-consumer logic, and reports each byte as a one-cycle valid pulse, or a framing-error pulse.

## Interface
- BAUD_RATE, 9600: line bit rate in bits/s.
- CLOCK_FREQ, 50000000: clk frequency in Hz.
- Derived constant DIV = CLOCK_FREQ / (BAUD_RATE*16), integer-truncated (325 at defaults). DIV must be ≥ 2.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line, idle high.
- data_out  out  8  last correctly framed byte; held until the next valid frame.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_error  out  1  one-cycle pulse when the stop bit samples low.
- rx_busy  out  1  high while the FSM is outside IDLE.

## Operation
- Synchroniser: rx_serial passes through 2 flops to give rx_sync. Both flops reset to 1.
- Tick generator: a free-running counter over 0..DIV-1. tick is high for one clk when the counter equals DIV-1, then the counter wraps to 0. The counter resets to 0.
- sample_cnt (4 bits) and bit_idx (3 bits) advance only on tick.
- FSM states: IDLE, START, DATA, STOP. The FSM resets to IDLE.
- IDLE: on a tick with rx_sync==0, go to START with sample_cnt=0.
- Every non-IDLE state: on each tick, sample_cnt increments. rx_sync is captured at sample_cnt = 7, 8 and 9. The bit value is the majority of those 3 samples.
- START: at sample_cnt==15, if the majority is 1 it is a false start; return to IDLE with no pulse. Otherwise go to DATA with bit_idx=0 and sample_cnt wrapping to 0.
- DATA: at sample_cnt==15, shift the majority in at bit 7 of the shift register (right-shift, so LSB first). When bit_idx==7 go to STOP; otherwise increment bit_idx.
- STOP: the decision is taken at the tick where sample_cnt==9, after the third vote.
  - Majority 1: load data_out from the shift register and pulse data_valid.
  - Majority 0: pulse frame_error; data_out is unchanged.
  - Either way, return to IDLE at that tick. The second half of the stop bit is spent in IDLE, so an immediately following start bit is detected.
- data_valid and frame_error are never high in the same cycle.
- rx_busy = (state != IDLE), registered with the state.

## Timing
- Reset values: data_out=0x00, data_valid=0, frame_error=0, rx_busy=0. Internal state: shift register 0, sample_cnt 0, bit_idx 0.
- rst mid-frame aborts with no pulse. Reception resumes with the next falling edge seen after rst deasserts.
- Input latency is 2 clk through the synchroniser. Start detection adds up to 1 tick (DIV clk) of quantisation.
- Bit period is 16 ticks = 16*DIV clk (5200 clk at defaults).
- Samples fall at ticks 7, 8 and 9 of each bit, i.e. about mid-bit.
- data_valid / frame_error:
  - Both are registered, so they go high the clk after the STOP-state tick with sample_cnt==9.
  - Each is high for exactly 1 clk.
  - data_out changes in the same cycle that data_valid rises.
- Nominal end-to-end latency: from the falling edge of the start bit to data_valid is about 9.56 bit periods, plus 2–3 clk, plus up to DIV clk.
- There is no backpressure. The consumer must sample data_out within one frame time (about 10 bit periods) of data_valid.
- Tolerated baud mismatch is at least ±3% (the mid-bit sample window is about ±3/16 bit at bit 9).
- A low pulse shorter than 8 ticks seen in IDLE is rejected as a false start.

## Test plan
Conditions for all scenarios: 50 MHz clk (20 ns period), DIV=325, bit time 104 µs.
- Valid byte:
  - Stimulus: drive 0xA5 as 8N1 (line 0,1,0,1,0,0,1,0,1,1).
  - Response: exactly one data_valid pulse, 1 clk wide; data_out=0xA5; frame_error stays 0; rx_busy falls in the cycle after the pulse.
- Back-to-back bytes:
  - Stimulus: 0x00 then 0xFF, with the second start bit immediately after a 1-bit stop.
  - Response: two data_valid pulses 10 bit times apart; data_out=0x00, then 0xFF.
- False start:
  - Stimulus: from idle, pull rx_serial low for 3 ticks (975 clk), then high.
  - Response: no pulses; rx_busy returns to 0 within 16 ticks.
  - Follow-up: 0x3C sent afterwards is received correctly.
- Framing error:
  - Stimulus: receive 0x11 validly, then send 0x3C with the stop bit held low.
  - Response: one frame_error pulse; no data_valid; data_out stays 0x11.
- Noise and baud skew:
  - Stimulus: invert rx_serial for 1 tick at sample 8 of data bit 3 of 0x5A; also send 0xC3 at +2.5% and at -2.5% baud.
  - Response: data_out=0x5A, then 0xC3 twice; no frame_error.
- Reset mid-frame:
  - Stimulus: assert rst for 2 clk during data bit 4 of 0xE7, then send 0x81.
  - Response: all outputs 0 in the cycle after the rst edge; no pulse for 0xE7; data_out=0x81 with one data_valid.
